// File: rtl/pll_cntr_cfg_pkg.sv
// Shared definitions for the PLL scale-counter reconfiguration sequencer.
//   - FLD_*  : cfg_field encodings for the staged register being written
//   - MODE_* : scale-counter operating modes
//   - state_e: commit sequencer states
package pll_cntr_cfg_pkg;

  localparam logic [1:0] FLD_HIGH = 2'd0;
  localparam logic [1:0] FLD_LOW  = 2'd1;
  localparam logic [1:0] FLD_INIT = 2'd2;
  localparam logic [1:0] FLD_MODE = 2'd3;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_BYPASS = 2'd1;
  localparam logic [1:0] MODE_EVEN   = 2'd2;
  localparam logic [1:0] MODE_ODD    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WAIT_BND,
    ST_RST_HOLD,
    ST_NEXT,
    ST_DONE
  } state_e;

  // Off and bypass counters never produce a period-restart pulse.
  function automatic logic mode_has_boundary(input logic [1:0] mode);
    return (mode == MODE_EVEN) || (mode == MODE_ODD);
  endfunction

endpackage

// File: rtl/pll_cntr_cfg_slot.sv
// Staged and live configuration for one PLL scale counter.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   wr_en_i            : write wr_data_i into staged field wr_field_i, mark it dirty
//   wr_field_i         : FLD_* code
//   wr_data_i          : write value (mode uses [1:0])
//   copy_hl_i          : staged high/low -> live
//   copy_all_i         : all staged fields -> live
//   clr_dirty_i        : clear all dirty bits
//   dirty_o            : dirty bits indexed by FLD_* code
//   live_*_o           : live fields driving the counter
module pll_cntr_cfg_slot
  import pll_cntr_cfg_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DEF_HIGH = 1,
  parameter int unsigned DEF_LOW  = 1,
  parameter int unsigned DEF_INIT = 1,
  parameter logic [1:0]  DEF_MODE = 2'd1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_field_i,
  input  logic [CNT_W-1:0] wr_data_i,
  input  logic             copy_hl_i,
  input  logic             copy_all_i,
  input  logic             clr_dirty_i,
  output logic [3:0]       dirty_o,
  output logic [CNT_W-1:0] live_high_o,
  output logic [CNT_W-1:0] live_low_o,
  output logic [CNT_W-1:0] live_init_o,
  output logic [1:0]       live_mode_o
);

  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] RST_LOW  = CNT_W'(DEF_LOW);
  localparam logic [CNT_W-1:0] RST_INIT = CNT_W'(DEF_INIT);

  logic [CNT_W-1:0] stg_high_q, stg_low_q, stg_init_q;
  logic [1:0]       stg_mode_q;
  logic [CNT_W-1:0] live_high_q, live_low_q, live_init_q;
  logic [1:0]       live_mode_q;
  logic [3:0]       dirty_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_high_q <= RST_HIGH;
      stg_low_q  <= RST_LOW;
      stg_init_q <= RST_INIT;
      stg_mode_q <= DEF_MODE;
    end else if (wr_en_i) begin
      case (wr_field_i)
        FLD_HIGH: stg_high_q <= wr_data_i;
        FLD_LOW:  stg_low_q  <= wr_data_i;
        FLD_INIT: stg_init_q <= wr_data_i;
        default:  stg_mode_q <= wr_data_i[1:0];
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dirty_q <= '0;
    end else if (clr_dirty_i) begin
      dirty_q <= '0;
    end else if (wr_en_i) begin
      dirty_q[wr_field_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_high_q <= RST_HIGH;
      live_low_q  <= RST_LOW;
      live_init_q <= RST_INIT;
      live_mode_q <= DEF_MODE;
    end else if (copy_all_i) begin
      live_high_q <= stg_high_q;
      live_low_q  <= stg_low_q;
      live_init_q <= stg_init_q;
      live_mode_q <= stg_mode_q;
    end else if (copy_hl_i) begin
      live_high_q <= stg_high_q;
      live_low_q  <= stg_low_q;
    end
  end

  assign dirty_o     = dirty_q;
  assign live_high_o = live_high_q;
  assign live_low_o  = live_low_q;
  assign live_init_o = live_init_q;
  assign live_mode_o = live_mode_q;

endmodule

// File: rtl/pll_cntr_reconfig_ctrl.sv
// Run-time reconfiguration sequencer for a bank of PLL scale-down counters.
// Host writes are staged per counter; a commit walks the counters in order,
// landing high/low changes on the counter's period boundary and applying
// initial/mode changes under a counter reset.
//   clk, reset_n        : clock, asynchronous active-low reset
//   cfg_valid/ready     : staged-write handshake (ready only in IDLE)
//   cfg_idx/field/data  : target counter, field code, value
//   cfg_err             : one-cycle pulse when a write is dropped
//   apply_req           : commit request, sampled in IDLE
//   apply_busy/done     : commit in progress / one-cycle completion pulse
//   apply_timeout       : sticky, a boundary wait expired during the last commit
//   cntr_boundary       : per-counter period-restart pulses
//   cntr_reset          : per-counter reset (active high)
//   cntr_high/low/init  : live fields, counter i at [i*CNT_W +: CNT_W]
//   cntr_mode           : live modes, counter i at [i*2 +: 2]
module pll_cntr_reconfig_ctrl
  import pll_cntr_cfg_pkg::*;
#(
  parameter int unsigned NUM_CNTR    = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned BND_TIMEOUT = 1024,
  parameter int unsigned DEF_HIGH    = 1,
  parameter int unsigned DEF_LOW     = 1,
  parameter int unsigned DEF_INIT    = 1,
  parameter logic [1:0]  DEF_MODE    = 2'd1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [3:0]                cfg_idx,
  input  logic [1:0]                cfg_field,
  input  logic [CNT_W-1:0]          cfg_data,
  output logic                      cfg_err,
  input  logic                      apply_req,
  output logic                      apply_busy,
  output logic                      apply_done,
  output logic                      apply_timeout,
  input  logic [NUM_CNTR-1:0]       cntr_boundary,
  output logic [NUM_CNTR-1:0]       cntr_reset,
  output logic [NUM_CNTR*CNT_W-1:0] cntr_high,
  output logic [NUM_CNTR*CNT_W-1:0] cntr_low,
  output logic [NUM_CNTR*CNT_W-1:0] cntr_init,
  output logic [NUM_CNTR*2-1:0]     cntr_mode
);

  localparam int unsigned IDX_W  = $clog2(NUM_CNTR + 1);
  localparam int unsigned TMO_W  = $clog2(BND_TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);

  localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(NUM_CNTR);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(BND_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic              err_q;
  logic              alive_q;

  logic       wr_bad, wr_accept;
  logic       copy_hl_s, copy_all_s, clr_dirty_s, rst_active;
  logic [3:0] dirty_w [NUM_CNTR];
  logic [3:0] cur_dirty;
  logic [1:0] cur_mode;
  logic       cur_bnd;
  logic       cur_need_rst;
  logic       hl_land;

  // ---------------------------------------------------------------------------
  // Host write path
  // ---------------------------------------------------------------------------
  assign wr_bad    = (32'(cfg_idx) >= NUM_CNTR) ||
                     ((cfg_field != FLD_MODE) && (cfg_data == '0));
  assign wr_accept = cfg_valid && cfg_ready && !wr_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      err_q   <= cfg_valid && cfg_ready && wr_bad;
      alive_q <= 1'b1;
    end
  end

  assign cfg_err       = err_q;
  assign apply_timeout = tmo_flag_q;

  // ---------------------------------------------------------------------------
  // Selected-counter view (idx_q may equal NUM_CNTR at the end of a scan)
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_dirty = '0;
    cur_mode  = MODE_OFF;
    cur_bnd   = 1'b0;
    for (int unsigned k = 0; k < NUM_CNTR; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_dirty = dirty_w[k];
        cur_mode  = cntr_mode[k*2 +: 2];
        cur_bnd   = cntr_boundary[k];
      end
    end
  end

  assign cur_need_rst = cur_dirty[FLD_INIT] || cur_dirty[FLD_MODE];
  assign hl_land      = cur_bnd || !mode_has_boundary(cur_mode);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tmo_q      <= '0;
      hold_q     <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      hold_q     <= hold_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // A clean counter is skipped inside SCAN in one cycle (nothing to clear),
  // and the end-of-bank check lives in SCAN, so an all-clean commit takes
  // NUM_CNTR+1 SCAN cycles followed by DONE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    hold_d     = hold_q;
    tmo_flag_d = tmo_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (apply_req) begin
          state_d    = ST_SCAN;
          idx_d      = '0;
          tmo_flag_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (idx_q == IDX_END) begin
          state_d = ST_DONE;
        end else if (cur_dirty == '0) begin
          idx_d = idx_q + IDX_W'(1);
        end else if (cur_need_rst) begin
          state_d = ST_RST_HOLD;
          hold_d  = '0;
        end else begin
          state_d = ST_WAIT_BND;
          tmo_d   = '0;
        end
      end
      ST_WAIT_BND: begin
        if (hl_land) begin
          state_d = ST_NEXT;
        end else if (tmo_q == TMO_MAX) begin
          state_d    = ST_RST_HOLD;
          hold_d     = '0;
          tmo_flag_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_NEXT;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_NEXT: begin
        state_d = ST_SCAN;
        idx_d   = idx_q + IDX_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and slot strobes
  // The full copy is issued on the edge entering RST_HOLD so the new fields
  // are already live during the first cycle cntr_reset is high.
  // ---------------------------------------------------------------------------
  always_comb begin
    copy_hl_s   = 1'b0;
    copy_all_s  = 1'b0;
    clr_dirty_s = 1'b0;
    rst_active  = 1'b0;
    apply_done  = 1'b0;
    apply_busy  = 1'b0;
    cfg_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready = alive_q;
      end
      ST_SCAN: begin
        apply_busy = 1'b1;
        copy_all_s = (idx_q != IDX_END) && cur_need_rst;
      end
      ST_WAIT_BND: begin
        apply_busy = 1'b1;
        copy_hl_s  = hl_land;
        copy_all_s = !hl_land && (tmo_q == TMO_MAX);
      end
      ST_RST_HOLD: begin
        apply_busy = 1'b1;
        rst_active = 1'b1;
      end
      ST_NEXT: begin
        apply_busy  = 1'b1;
        clr_dirty_s = 1'b1;
      end
      ST_DONE: begin
        apply_done = 1'b1;
      end
      default: begin
        apply_busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter slots
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CNTR; gi++) begin : g_slot
    logic sel;
    logic wr_sel;

    assign sel    = (idx_q == IDX_W'(gi));
    assign wr_sel = wr_accept && (cfg_idx == 4'(gi));

    pll_cntr_cfg_slot #(
      .CNT_W    (CNT_W),
      .DEF_HIGH (DEF_HIGH),
      .DEF_LOW  (DEF_LOW),
      .DEF_INIT (DEF_INIT),
      .DEF_MODE (DEF_MODE)
    ) u_slot (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .wr_en_i     (wr_sel),
      .wr_field_i  (cfg_field),
      .wr_data_i   (cfg_data),
      .copy_hl_i   (copy_hl_s && sel),
      .copy_all_i  (copy_all_s && sel),
      .clr_dirty_i (clr_dirty_s && sel),
      .dirty_o     (dirty_w[gi]),
      .live_high_o (cntr_high[gi*CNT_W +: CNT_W]),
      .live_low_o  (cntr_low[gi*CNT_W +: CNT_W]),
      .live_init_o (cntr_init[gi*CNT_W +: CNT_W]),
      .live_mode_o (cntr_mode[gi*2 +: 2])
    );

    assign cntr_reset[gi] = rst_active && sel;
  end

endmodule
